// File: rtl/dallanma_ongorucu.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters; registered prediction 1 cycle after request.
// Fetch stall freezes the prediction outputs and drops new requests; execute-stage training is never stalled.
module dallanma_ongorucu #(
  parameter int PS_BIT    = 32,
  parameter int BTB_SATIR = 64,
  parameter int SAYAC_BIT = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PS_BIT-1:0]    ongoru_ps_i,
  input  logic                 ongoru_gecerli_i,
  input  logic                 cek_duraklat_i,
  output logic                 ongoru_gecerli_o,
  output logic                 ongoru_atla_o,
  output logic [PS_BIT-1:0]    ongoru_hedef_o,
  input  logic [PS_BIT-1:0]    g2_ps_i,
  input  logic [PS_BIT-1:0]    g2_hedef_ps_i,
  input  logic                 g2_guncelle_i,
  input  logic                 g2_atladi_i,
  input  logic                 g2_hatali_tahmin_i,
  output logic [SAYAC_BIT-1:0] hatali_sayac_o
);

  localparam int IDX_BIT = $clog2(BTB_SATIR);
  localparam int TAG_BIT = PS_BIT - IDX_BIT - 1;

  logic [BTB_SATIR-1:0] gecerli_q;
  logic [TAG_BIT-1:0]   etiket_q [BTB_SATIR];
  logic [PS_BIT-1:0]    hedef_q  [BTB_SATIR];
  logic [1:0]           sayac_q  [BTB_SATIR];

  // ps[0] never participates: instructions are at least 2-byte aligned.
  logic unused_ps0;
  assign unused_ps0 = ongoru_ps_i[0] ^ g2_ps_i[0];

  logic [IDX_BIT-1:0] o_idx;
  logic [TAG_BIT-1:0] o_etiket;
  logic               o_isabet;
  logic               o_atla;

  assign o_idx    = ongoru_ps_i[IDX_BIT:1];
  assign o_etiket = ongoru_ps_i[PS_BIT-1:IDX_BIT+1];
  assign o_isabet = gecerli_q[o_idx] && (etiket_q[o_idx] == o_etiket);
  assign o_atla   = ongoru_gecerli_i && o_isabet && sayac_q[o_idx][1];

  // Reads the arrays before this cycle's training write lands (read-before-write).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ongoru_gecerli_o <= 1'b0;
      ongoru_atla_o    <= 1'b0;
      ongoru_hedef_o   <= '0;
    end else if (!cek_duraklat_i) begin
      ongoru_gecerli_o <= ongoru_gecerli_i;
      ongoru_atla_o    <= o_atla;
      ongoru_hedef_o   <= o_atla ? hedef_q[o_idx] : '0;
    end
  end

  logic [IDX_BIT-1:0] g_idx;
  logic [TAG_BIT-1:0] g_etiket;
  logic               g_isabet;
  logic [1:0]         g_sayac_yeni;

  assign g_idx    = g2_ps_i[IDX_BIT:1];
  assign g_etiket = g2_ps_i[PS_BIT-1:IDX_BIT+1];
  assign g_isabet = gecerli_q[g_idx] && (etiket_q[g_idx] == g_etiket);

  always_comb begin
    g_sayac_yeni = sayac_q[g_idx];
    if (g2_atladi_i) begin
      if (sayac_q[g_idx] != 2'b11) g_sayac_yeni = sayac_q[g_idx] + 2'd1;
    end else begin
      if (sayac_q[g_idx] != 2'b00) g_sayac_yeni = sayac_q[g_idx] - 2'd1;
    end
  end

  // Only the valid bits are reset; tag/target/counter are don't-care until allocated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gecerli_q <= '0;
    end else if (g2_guncelle_i) begin
      if (g_isabet) begin
        sayac_q[g_idx] <= g_sayac_yeni;
        if (g2_atladi_i) hedef_q[g_idx] <= g2_hedef_ps_i;
      end else if (g2_atladi_i) begin
        gecerli_q[g_idx] <= 1'b1;
        etiket_q[g_idx]  <= g_etiket;
        hedef_q[g_idx]   <= g2_hedef_ps_i;
        sayac_q[g_idx]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hatali_sayac_o <= '0;
    end else if (g2_guncelle_i && g2_hatali_tahmin_i && (hatali_sayac_o != '1)) begin
      hatali_sayac_o <= hatali_sayac_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Scoreboard bench for dallanma_ongorucu: expected predictions queued at request, compared per scenario.
module tb_dallanma_ongorucu;
  localparam int PB = 32;
  localparam int NS = 64;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [PB-1:0] ongoru_ps;
  logic          ongoru_gecerli;
  logic          cek_duraklat;
  logic          gecerli_o;
  logic          atla_o;
  logic [PB-1:0] hedef_o;
  logic [PB-1:0] g2_ps;
  logic [PB-1:0] g2_hedef;
  logic          g2_guncelle;
  logic          g2_atladi;
  logic          g2_hatali;
  logic [SB-1:0] hatali_sayac;

  always #5 clk = ~clk;

  dallanma_ongorucu #(.PS_BIT(PB), .BTB_SATIR(NS), .SAYAC_BIT(SB)) dut (
    .clk_i(clk), .rst_i(rst),
    .ongoru_ps_i(ongoru_ps), .ongoru_gecerli_i(ongoru_gecerli), .cek_duraklat_i(cek_duraklat),
    .ongoru_gecerli_o(gecerli_o), .ongoru_atla_o(atla_o), .ongoru_hedef_o(hedef_o),
    .g2_ps_i(g2_ps), .g2_hedef_ps_i(g2_hedef), .g2_guncelle_i(g2_guncelle),
    .g2_atladi_i(g2_atladi), .g2_hatali_tahmin_i(g2_hatali), .hatali_sayac_o(hatali_sayac)
  );

  typedef logic [PB+1:0] cikis_t;
  cikis_t exp_q[$];
  cikis_t obs_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [PB-1:0] ps, input logic a, input logic [PB-1:0] h);
    ongoru_ps = ps;
    ongoru_gecerli = 1'b1;
    exp_q.push_back({1'b1, a, h});
    step();
    obs_q.push_back({gecerli_o, atla_o, hedef_o});
    ongoru_gecerli = 1'b0;
  endtask

  task automatic update(input logic [PB-1:0] ps, input logic [PB-1:0] tgt, input logic tk, input logic mis);
    g2_ps = ps; g2_hedef = tgt; g2_atladi = tk; g2_hatali = mis; g2_guncelle = 1'b1;
    step();
    g2_guncelle = 1'b0; g2_hatali = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    vectors++;
    if ({gecerli_o, atla_o, hedef_o, hatali_sayac} !== '0) begin
      miscompares++;
      $display("FAIL reset: got vld=%0b atla=%0b hedef=%h cnt=%0d, want all zero",
               gecerli_o, atla_o, hedef_o, hatali_sayac);
    end
    lookup(32'h100, 1'b0, 32'h0);
    while (exp_q.size() > 0) begin
      cikis_t e = exp_q.pop_front(); cikis_t o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reset_lookup: got %h want %h", o, e); end
    end
  endtask

  task automatic test_train();
    update(32'h100, 32'h200, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h200);
    lookup(32'h101, 1'b1, 32'h200);
    while (exp_q.size() > 0) begin
      cikis_t e = exp_q.pop_front(); cikis_t o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL train: got %h want %h", o, e); end
    end
  endtask

  task automatic test_saturate();
    update(32'h100, 32'h0, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 32'h0);
    update(32'h100, 32'h0, 1'b0, 1'b0);
    update(32'h100, 32'h0, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) update(32'h100, 32'h220, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h220);
    update(32'h100, 32'h999, 1'b0, 1'b0);
    lookup(32'h100, 1'b1, 32'h220);
    update(32'h100, 32'h999, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 32'h0);
    while (exp_q.size() > 0) begin
      cikis_t e = exp_q.pop_front(); cikis_t o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL saturate: got %h want %h", o, e); end
    end
  endtask

  task automatic test_alias();
    update(32'h100, 32'h200, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h200);
    update(32'h100 + 2 * NS, 32'h300, 1'b1, 1'b0);
    lookup(32'h100, 1'b0, 32'h0);
    lookup(32'h100 + 2 * NS, 1'b1, 32'h300);
    update(32'h500, 32'h700, 1'b0, 1'b0);
    lookup(32'h500, 1'b0, 32'h0);
    lookup(32'h100 + 2 * NS, 1'b1, 32'h300);
    while (exp_q.size() > 0) begin
      cikis_t e = exp_q.pop_front(); cikis_t o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL alias: got %h want %h", o, e); end
    end
  endtask

  task automatic test_same_cycle();
    g2_ps = 32'h140; g2_hedef = 32'h444; g2_atladi = 1'b1; g2_guncelle = 1'b1;
    lookup(32'h140, 1'b0, 32'h0);
    g2_guncelle = 1'b0;
    lookup(32'h140, 1'b1, 32'h444);
    while (exp_q.size() > 0) begin
      cikis_t e = exp_q.pop_front(); cikis_t o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL same_cycle: got %h want %h", o, e); end
    end
  endtask

  task automatic test_idle();
    lookup(32'h140, 1'b1, 32'h444);
    step();
    vectors++;
    if (gecerli_o !== 1'b0) begin
      miscompares++; $display("FAIL idle_vld: got %0b want 0", gecerli_o);
    end
    while (exp_q.size() > 0) begin
      cikis_t e = exp_q.pop_front(); cikis_t o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL idle: got %h want %h", o, e); end
    end
  endtask

  task automatic test_stall();
    logic [PB-1:0] adr [3];
    adr[0] = 32'h100; adr[1] = 32'h140; adr[2] = 32'h7fe;
    lookup(32'h180, 1'b1, 32'h300);
    cek_duraklat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ongoru_ps = adr[i];
      ongoru_gecerli = i[0];
      if (i == 1) begin
        g2_ps = 32'h100; g2_hedef = 32'h600; g2_atladi = 1'b1; g2_guncelle = 1'b1;
      end
      exp_q.push_back({1'b1, 1'b1, 32'h300});
      step();
      g2_guncelle = 1'b0;
      obs_q.push_back({gecerli_o, atla_o, hedef_o});
    end
    cek_duraklat = 1'b0;
    ongoru_gecerli = 1'b0;
    lookup(32'h100, 1'b1, 32'h600);
    while (exp_q.size() > 0) begin
      cikis_t e = exp_q.pop_front(); cikis_t o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL stall: got %h want %h", o, e); end
    end
  endtask

  task automatic test_counter();
    for (int i = 0; i < 14; i++) update(32'h7000, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (hatali_sayac !== 4'd14) begin
      miscompares++; $display("FAIL cnt_preload: got %0d want 14", hatali_sayac);
    end
    update(32'h7000, 32'h0, 1'b0, 1'b0);
    g2_hatali = 1'b1;
    step();
    g2_hatali = 1'b0;
    vectors++;
    if (hatali_sayac !== 4'd14) begin
      miscompares++; $display("FAIL cnt_no_strobe: got %0d want 14", hatali_sayac);
    end
    update(32'h7000, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (hatali_sayac !== 4'd15) begin
      miscompares++; $display("FAIL cnt_max: got %0d want 15", hatali_sayac);
    end
    update(32'h7000, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (hatali_sayac !== 4'd15) begin
      miscompares++; $display("FAIL cnt_saturate: got %0d want 15", hatali_sayac);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    ongoru_ps = 32'h180; ongoru_gecerli = 1'b1;
    g2_ps = 32'h900; g2_hedef = 32'h123; g2_atladi = 1'b1; g2_guncelle = 1'b1;
    step();
    rst = 1'b0; ongoru_gecerli = 1'b0; g2_guncelle = 1'b0;
    vectors++;
    if ({gecerli_o, atla_o, hedef_o, hatali_sayac} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got vld=%0b atla=%0b hedef=%h cnt=%0d, want all zero",
               gecerli_o, atla_o, hedef_o, hatali_sayac);
    end
    lookup(32'h100, 1'b0, 32'h0);
    lookup(32'h140, 1'b0, 32'h0);
    lookup(32'h180, 1'b0, 32'h0);
    lookup(32'h900, 1'b0, 32'h0);
    while (exp_q.size() > 0) begin
      cikis_t e = exp_q.pop_front(); cikis_t o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reset_mid_lookup: got %h want %h", o, e); end
    end
  endtask

  initial begin
    rst = 1'b1; ongoru_ps = '0; ongoru_gecerli = 1'b0; cek_duraklat = 1'b0;
    g2_ps = '0; g2_hedef = '0; g2_guncelle = 1'b0; g2_atladi = 1'b0; g2_hatali = 1'b0;
    test_reset();
    test_train();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_idle();
    test_stall();
    test_counter();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
